// File: rtl/datapath_seq.sv
// Instruction sequencer for the 4-register ALU datapath. Micro-instructions are
// queued in a FIFO and issued as SETUP -> EXEC (write strobe) -> DONE.
module datapath_seq #(
  parameter int WORD_SIZE = 32,
  parameter int DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_op,
  input  logic [1:0]           in_src1,
  input  logic [1:0]           in_src2,
  input  logic [1:0]           in_dst,
  output logic [1:0]           dp_addr1,
  output logic [1:0]           dp_addr2,
  output logic [1:0]           dp_addr3,
  output logic [2:0]           dp_alu,
  output logic                 dp_wr,
  input  logic [WORD_SIZE-1:0] dp_result,
  input  logic                 dp_cout,
  output logic                 done,
  output logic [WORD_SIZE-1:0] done_result,
  output logic                 done_cout,
  output logic                 done_zero,
  output logic                 done_err,
  output logic                 busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Instruction word layout: {op[2:0], src1[1:0], src2[1:0], dst[1:0]}
  logic [8:0]           fifo_q [DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        count_q;
  logic                 full_s, empty_s, push_s, pop_s;
  logic [8:0]           head_s;

  logic [1:0]           state_q, state_d;
  logic [2:0]           cur_op_q, cur_op_d;
  logic [1:0]           addr1_q, addr1_d, addr2_q, addr2_d, addr3_q, addr3_d;
  logic [2:0]           alu_q, alu_d;
  logic                 wr_q, wr_d;
  logic                 done_q, done_d;
  logic [WORD_SIZE-1:0] res_q, res_d;
  logic                 cout_q, cout_d, zero_q, zero_d, err_q, err_d;

  assign full_s   = (count_q == CW'(DEPTH));
  assign empty_s  = (count_q == {CW{1'b0}});
  assign push_s   = in_valid & ~full_s;
  assign pop_s    = ~empty_s & ((state_q == S_IDLE) | (state_q == S_DONE));
  assign head_s   = fifo_q[rd_ptr_q];

  assign in_ready    = ~full_s;
  assign busy        = (state_q != S_IDLE) | ~empty_s;
  assign dp_addr1    = addr1_q;
  assign dp_addr2    = addr2_q;
  assign dp_addr3    = addr3_q;
  assign dp_alu      = alu_q;
  assign dp_wr       = wr_q;
  assign done        = done_q;
  assign done_result = res_q;
  assign done_cout   = cout_q;
  assign done_zero   = zero_q;
  assign done_err    = err_q;

  // FIFO storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_q[wr_ptr_q] <= {in_op, in_src1, in_src2, in_dst};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_s)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_s, pop_s})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    cur_op_d = cur_op_q;
    addr1_d  = addr1_q;
    addr2_d  = addr2_q;
    addr3_d  = addr3_q;
    alu_d    = alu_q;
    wr_d     = 1'b0;
    done_d   = 1'b0;
    res_d    = res_q;
    cout_d   = cout_q;
    zero_d   = zero_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (pop_s) begin
          cur_op_d = head_s[8:6];
          addr1_d  = head_s[5:4];
          addr2_d  = head_s[3:2];
          addr3_d  = head_s[1:0];
          alu_d    = {1'b0, head_s[7:6]};
          state_d  = S_SETUP;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_SETUP: begin
        // Illegal ops retire with an error and never strobe a write.
        if (cur_op_q[2]) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          res_d   = {WORD_SIZE{1'b0}};
          cout_d  = 1'b0;
          zero_d  = 1'b0;
          err_d   = 1'b1;
        end else begin
          state_d = S_EXEC;
          wr_d    = 1'b1;
        end
      end
      S_EXEC: begin
        state_d = S_DONE;
        done_d  = 1'b1;
        res_d   = dp_result;
        cout_d  = dp_cout;
        zero_d  = (dp_result == {WORD_SIZE{1'b0}});
        err_d   = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cur_op_q <= 3'd0;
      addr1_q  <= 2'd0;
      addr2_q  <= 2'd0;
      addr3_q  <= 2'd0;
      alu_q    <= 3'd0;
      wr_q     <= 1'b0;
      done_q   <= 1'b0;
      res_q    <= {WORD_SIZE{1'b0}};
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_op_q <= cur_op_d;
      addr1_q  <= addr1_d;
      addr2_q  <= addr2_d;
      addr3_q  <= addr3_d;
      alu_q    <= alu_d;
      wr_q     <= wr_d;
      done_q   <= done_d;
      res_q    <= res_d;
      cout_q   <= cout_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
    end
  end

endmodule
